// File: rtl/adxl_spi_reader.sv
// adxl_spi_reader: SPI mode-0 master that puts an ADXL-style accelerometer in
// measurement mode once, then periodically reads the X/Y/Z registers.
module adxl_spi_reader #(
  parameter int SCLK_HALF  = 12,
  parameter int SAMPLE_GAP = 100000
) (
  input  logic       ClkPort,
  input  logic       Reset_n,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_n,
  output logic [7:0] acc_x,
  output logic [7:0] acc_y,
  output logic [7:0] acc_z,
  output logic       data_valid,
  output logic       busy
);
  // The gap never drops below one full bit time so CS_n stays high long enough.
  localparam int GAP_N = SAMPLE_GAP > 2 * SCLK_HALF ? SAMPLE_GAP : 2 * SCLK_HALF;
  localparam int GW    = GAP_N > 1 ? $clog2(GAP_N) : 1;
  localparam int HW    = SCLK_HALF > 1 ? $clog2(SCLK_HALF) : 1;
  typedef enum logic [2:0] {RST, INIT, GAP, READ, LATCH} state_t;
  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [5:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [39:0]   tx_q, tx_d;
  logic [23:0]   rx_q, rx_d, acc_q, acc_d;
  logic          sclk_q, sclk_d, cs_n_q, cs_n_d, tail_q, tail_d, dv_q, dv_d;
  logic          half_end, last_bit;
  assign half_end = half_q == HW'(SCLK_HALF - 1);
  assign last_bit = bit_q == (state_q == INIT ? 6'd23 : 6'd39);
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    acc_d   = acc_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    tail_d  = tail_q;
    dv_d    = 1'b0;
    case (state_q)
      RST: begin
        state_d = INIT;
        cs_n_d  = 1'b0;
        tx_d    = {24'h0A2D02, 16'h0000};
      end
      INIT, READ: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          // Tail phase: SCLK already low after the last fall; now release CS_n.
          if (tail_q) begin
            cs_n_d  = 1'b1;
            tail_d  = 1'b0;
            bit_d   = '0;
            tx_d    = '0;
            state_d = state_q == INIT ? GAP : LATCH;
          end else if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = (state_q == READ && bit_q >= 6'd16) ? {rx_q[22:0], MISO} : rx_q;
          end else begin
            sclk_d = 1'b0;
            tail_d = last_bit;
            bit_d  = last_bit ? bit_q : bit_q + 1'b1;
            tx_d   = last_bit ? tx_q : {tx_q[38:0], 1'b0};
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_N - 1)) begin
          gap_d   = '0;
          state_d = READ;
          cs_n_d  = 1'b0;
          tx_d    = {16'h0B08, 24'h000000};
        end
      end
      LATCH: begin
        acc_d   = rx_q;
        dv_d    = 1'b1;
        state_d = GAP;
      end
      default: state_d = RST;
    endcase
  end
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RST;
      half_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      acc_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      tail_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      acc_q   <= acc_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      tail_q  <= tail_d;
      dv_q    <= dv_d;
    end
  end
  assign SCLK       = sclk_q;
  assign MOSI       = tx_q[39];
  assign CS_n       = cs_n_q;
  assign busy       = ~cs_n_q;
  assign data_valid = dv_q;
  assign acc_x      = acc_q[23:16];
  assign acc_y      = acc_q[15:8];
  assign acc_z      = acc_q[7:0];
endmodule

// File: tb/tb_adxl_spi_reader.sv
// tb_adxl_spi_reader: directed bench for adxl_spi_reader with a mode-0 MISO device model.
module tb_adxl_spi_reader;
  logic       ClkPort = 1'b0;
  logic       Reset_n = 1'b0;
  logic       MISO;
  logic       SCLK, MOSI, CS_n, data_valid, busy;
  logic [7:0] acc_x, acc_y, acc_z;
  logic [39:0] miso_pat = '0;
  logic [5:0]  nfall = '0;
  logic        sclk_prev = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  adxl_spi_reader #(.SCLK_HALF(12), .SAMPLE_GAP(50)) dut (
    .ClkPort(ClkPort), .Reset_n(Reset_n), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI),
    .CS_n(CS_n), .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
    .data_valid(data_valid), .busy(busy)
  );
  always #5 ClkPort = ~ClkPort;
  // Device model shifts its next bit out after every SCLK falling edge.
  always @(negedge ClkPort) begin
    if (CS_n !== 1'b0) nfall <= '0;
    else if (SCLK === 1'b0 && sclk_prev) nfall <= nfall + 6'd1;
    sclk_prev <= SCLK === 1'b1;
  end
  always_comb MISO = nfall < 6'd40 ? miso_pat[6'd39 - nfall] : 1'b0;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic [23:0] held, output logic [39:0] word, output int nrise,
                      output int t_first, output int t_tail, output int gap, output int bad,
                      output logic to);
    int c, last_fall, last_rise, waited;
    logic prev;
    word = '0; nrise = 0; t_first = -1; t_tail = -1; bad = 0; to = 1'b0;
    waited = 0; last_fall = 0; last_rise = 0; prev = 1'b0; c = 0; gap = 0;
    @(negedge ClkPort);
    while (CS_n !== 1'b0 && waited < 400) begin
      waited++;
      @(negedge ClkPort);
    end
    gap = waited + 1;
    if (CS_n !== 1'b0) begin
      to = 1'b1;
      return;
    end
    while (CS_n === 1'b0 && c < 2000) begin
      if (busy !== 1'b1 || {acc_x, acc_y, acc_z} !== held) bad++;
      if (SCLK === 1'b1 && !prev) begin
        if (nrise == 0) t_first = c;
        else if (c - last_fall != 12) bad++;
        word = {word[38:0], MOSI};
        nrise++;
        last_rise = c;
      end
      if (SCLK === 1'b0 && prev) begin
        if (c - last_rise != 12) bad++;
        last_fall = c;
      end
      prev = SCLK === 1'b1;
      c++;
      @(negedge ClkPort);
    end
    if (CS_n !== 1'b1) to = 1'b1;
    if (SCLK !== 1'b0 || busy !== 1'b0) bad++;
    t_tail = c - last_fall;
  endtask
  task automatic check_timing(input string tag, input int t_first, input int t_tail,
                              input int bad, input logic to);
    chk({tag, "_timeout"}, 40'(to), 40'd0);
    chk({tag, "_cs_to_rise"}, 40'(t_first), 40'd12);
    chk({tag, "_fall_to_cs"}, 40'(t_tail), 40'd12);
    chk({tag, "_pulse_hold_busy"}, 40'(bad), 40'd0);
  endtask
  task automatic wait_dv(input string tag, input logic [23:0] exp);
    int w;
    w = 0;
    while (data_valid !== 1'b1 && w < 100) begin
      @(negedge ClkPort);
      w++;
    end
    chk({tag, "_dv"}, 40'(data_valid), 40'd1);
    chk({tag, "_acc_x"}, 40'(acc_x), 40'(exp[23:16]));
    chk({tag, "_acc_y"}, 40'(acc_y), 40'(exp[15:8]));
    chk({tag, "_acc_z"}, 40'(acc_z), 40'(exp[7:0]));
    @(negedge ClkPort);
    chk({tag, "_dv_one_cycle"}, 40'(data_valid), 40'd0);
  endtask
  initial begin
    logic [39:0] word;
    int nrise, t_first, t_tail, gap, bad, w;
    logic to;
    repeat (5) @(negedge ClkPort);
    chk("rst_sclk", 40'(SCLK), 40'd0);
    chk("rst_mosi", 40'(MOSI), 40'd0);
    chk("rst_cs_n", 40'(CS_n), 40'd1);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_dv", 40'(data_valid), 40'd0);
    chk("rst_acc", 40'({acc_x, acc_y, acc_z}), 40'd0);
    Reset_n = 1'b1;
    xact(24'h0, word, nrise, t_first, t_tail, gap, bad, to);
    chk("init_word", 40'(word[23:0]), 40'h0A2D02);
    chk("init_nrise", 40'(nrise), 40'd24);
    check_timing("init", t_first, t_tail, bad, to);
    miso_pat = {16'h0, 24'h123456};
    xact(24'h0, word, nrise, t_first, t_tail, gap, bad, to);
    chk("read1_cmd", 40'(word[39:24]), 40'h0B08);
    chk("read1_mosi_zero", 40'(word[23:0]), 40'd0);
    chk("read1_nrise", 40'(nrise), 40'd40);
    chk("read1_gap", 40'(gap >= 24), 40'd1);
    check_timing("read1", t_first, t_tail, bad, to);
    wait_dv("read1", 24'h123456);
    miso_pat = {16'h0, 24'hFF0080};
    xact(24'h123456, word, nrise, t_first, t_tail, gap, bad, to);
    chk("read2_cmd", 40'(word[39:24]), 40'h0B08);
    chk("read2_gap", 40'(gap >= 24), 40'd1);
    check_timing("read2", t_first, t_tail, bad, to);
    wait_dv("read2", 24'hFF0080);
    miso_pat = {16'h0, 24'h010203};
    xact(24'hFF0080, word, nrise, t_first, t_tail, gap, bad, to);
    chk("read3_nrise", 40'(nrise), 40'd40);
    chk("read3_gap", 40'(gap >= 24), 40'd1);
    check_timing("read3", t_first, t_tail, bad, to);
    wait_dv("read3", 24'h010203);
    miso_pat = {16'h0, 24'hAAAAAA};
    w = 0;
    while (CS_n !== 1'b0 && w < 400) begin
      @(negedge ClkPort);
      w++;
    end
    nrise = 0;
    sclk_prev_loop: while (nrise < 20 && w < 2000) begin
      @(posedge SCLK or negedge CS_n);
      if (CS_n !== 1'b0) break;
      nrise++;
      w++;
    end
    chk("midrst_reached_bit20", 40'(nrise), 40'd20);
    @(negedge ClkPort);
    Reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", 40'(CS_n), 40'd1);
    chk("midrst_sclk", 40'(SCLK), 40'd0);
    chk("midrst_acc", 40'({acc_x, acc_y, acc_z}), 40'd0);
    chk("midrst_busy", 40'(busy), 40'd0);
    repeat (3) @(negedge ClkPort);
    Reset_n = 1'b1;
    xact(24'h0, word, nrise, t_first, t_tail, gap, bad, to);
    chk("reinit_word", 40'(word[23:0]), 40'h0A2D02);
    chk("reinit_nrise", 40'(nrise), 40'd24);
    check_timing("reinit", t_first, t_tail, bad, to);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adxl_spi_reader.md
ADXL_SPI_READER -- requirements
Module: adxl_spi_reader

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 12: ClkPort cycles per SCLK half-period (100 MHz / 24 = 4.17 MHz SCLK).
REQ-002 SHALL have parameter SAMPLE_GAP, default 100000: ClkPort cycles from the end of one transaction to the start of the next read.
REQ-003 SHALL have port ClkPort  input  1  system clock, 100 MHz.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MISO  input  1  serial data from the accelerometer.
REQ-006 SHALL have port SCLK  output  1  SPI serial clock.
REQ-007 SHALL have port MOSI  output  1  serial data to the accelerometer.
REQ-008 SHALL have port CS_n  output  1  active-low chip select.
REQ-009 SHALL have ports acc_x, acc_y, acc_z  output  8 each  latest samples from registers 0x08, 0x09 and 0x0A.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse when acc_x/y/z update.
REQ-011 SHALL have port busy  output  1  high while CS_n is low.

Function
REQ-012 SHALL use SPI mode 0.
- SCLK idles low.
- MOSI changes on SCLK falling edges.
- MISO is sampled on SCLK rising edges.
- Data is MSB first.
REQ-013 SHALL derive SCLK from an internal counter 0..SCLK_HALF-1 that runs only while a transaction is active; SCLK SHALL NOT be produced by a generated clock.
REQ-014 SHALL make each bit exactly 2*SCLK_HALF ClkPort cycles: SCLK low for SCLK_HALF cycles, then high for SCLK_HALF cycles.
REQ-015 SHALL drive the first MOSI bit on the same cycle CS_n falls, so it is stable SCLK_HALF cycles before the first rising edge.
REQ-016 SHALL raise CS_n SCLK_HALF cycles after the last falling edge, with SCLK low.
REQ-017 SHALL hold CS_n high for at least 2*SCLK_HALF cycles between transactions.
REQ-018 SHALL implement states RST, INIT, GAP, READ, LATCH.
REQ-019 SHALL leave RST for INIT on the first clock after Reset_n deasserts.
REQ-020 SHALL, in INIT, send the 24-bit write 0x0A, 0x2D, 0x02 (measurement mode), then go to GAP.
REQ-021 SHALL, in GAP, count SAMPLE_GAP cycles with CS_n high, then go to READ.
REQ-022 SHALL, in READ, send 0x0B, 0x08, then clock in 24 bits: bits 23:16 to X, 15:8 to Y, 7:0 to Z; the whole read is 40 bits.
REQ-023 SHALL hold MOSI at 0 during the read-data bytes.
REQ-024 SHALL, in LATCH, update acc_x/y/z and pulse data_valid for exactly one cycle, then go to GAP.
REQ-025 SHALL send INIT only once per reset.
REQ-026 SHALL never update acc_x/y/z partially: the shift register is internal and copied to the outputs only in LATCH.
REQ-027 SHALL keep a 6-bit bit counter; wrap-around is impossible because the transaction ends at 24 or 40 bits.
REQ-028 SHALL sample MISO directly; no synchronizer is required because the device drives MISO off SCLK.

Reset
REQ-029 SHALL, while Reset_n is low, immediately force the following, regardless of state:
- SCLK=0, MOSI=0, CS_n=1, busy=0, data_valid=0.
- acc_x/y/z=0x00.
- state=RST, all counters 0.
REQ-030 SHALL, on reset asserted mid-transaction, abort it (CS_n high asynchronously) and restart from INIT after release.

Verification
REQ-031 SHALL pass a reset check: assert Reset_n=0 for 5 cycles -> all outputs hold their REQ-029 values.
REQ-032 SHALL pass an init check: release reset -> CS_n falls, 24 SCLK pulses each 24 cycles long, and the MOSI stream decodes to 0x0A2D02.
REQ-033 SHALL pass a read check, with SAMPLE_GAP=50: the MISO model returns 0x12, 0x34, 0x56 on bytes 3-5 -> MOSI decodes 0x0B08, then one data_valid pulse with acc_x=0x12, acc_y=0x34, acc_z=0x56.
REQ-034 SHALL pass a periodic-read check: two consecutive reads return 0xFF/0x00/0x80 then 0x01/0x02/0x03 -> the outputs hold the first set until the second LATCH and never show mixed values.
REQ-035 SHALL pass a mid-read reset check: pulse Reset_n low at bit 20 of a read -> CS_n goes high within the same cycle, acc_* clear to 0x00, and the next transaction is INIT (0x0A2D02).
REQ-036 SHALL pass a timing check: for every transaction, measure CS_n-low to first SCLK rise = SCLK_HALF, last SCLK fall to CS_n rise = SCLK_HALF, and CS_n-high gap >= 2*SCLK_HALF.
